// File: rtl/sync_debounce.sv
// Multi-channel input conditioner: each channel gets a synchronizer chain, then a
// sample-count debouncer producing a clean level plus registered rise/fall pulses.
module sync_debounce #(
    parameter int WIDTH     = 2,
    parameter int STAGES    = 2,
    parameter int DB_CYCLES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] sync_raw,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    localparam int CW = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_chan
            logic [STAGES-1:0] sync_q;
            logic [CW-1:0]     cnt_q, cnt_d;
            logic              level_q, level_d;
            logic              rise_q, rise_d;
            logic              fall_q, fall_d;
            logic              sync_bit;

            assign sync_bit = sync_q[STAGES-1];

            // The synchronizer keeps shifting even while the debouncer is frozen.
            always_ff @(posedge clk) begin
                if (!reset) begin
                    sync_q <= '0;
                end else begin
                    sync_q <= {sync_q[STAGES-2:0], d[gi]};
                end
            end

            always_comb begin
                cnt_d   = cnt_q;
                level_d = level_q;
                rise_d  = 1'b0;
                fall_d  = 1'b0;
                if (en) begin
                    if (sync_bit == level_q) begin
                        cnt_d = '0;
                    end else if (cnt_q == CNT_MAX) begin
                        // Pulses launch on the same edge as the level so they line up with q.
                        level_d = sync_bit;
                        cnt_d   = '0;
                        rise_d  = sync_bit;
                        fall_d  = ~sync_bit;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (!reset) begin
                    cnt_q   <= '0;
                    level_q <= 1'b0;
                    rise_q  <= 1'b0;
                    fall_q  <= 1'b0;
                end else begin
                    cnt_q   <= cnt_d;
                    level_q <= level_d;
                    rise_q  <= rise_d;
                    fall_q  <= fall_d;
                end
            end

            assign sync_raw[gi] = sync_bit;
            assign q[gi]        = level_q;
            assign rise[gi]     = rise_q;
            assign fall[gi]     = fall_q;
        end
    endgenerate

endmodule

// File: tb/tb_sync_debounce.sv
// Bench for sync_debounce (WIDTH=2, STAGES=2, DB_CYCLES=4): vector table for the
// basic latency cases, hand-built sequences for glitch, enable and reset corners.
module tb_sync_debounce;

    logic       clk;
    logic       reset;
    logic       en;
    logic [1:0] d;
    logic [1:0] sync_raw;
    logic [1:0] q;
    logic [1:0] rise;
    logic [1:0] fall;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic       rst_n;
        logic       en;
        logic [1:0] d;
        logic [1:0] sr;
        logic [1:0] q;
        logic [1:0] rise;
        logic [1:0] fall;
    } vec_t;

    typedef struct {
        string      tag;
        logic [1:0] sr;
        logic [1:0] q;
        logic [1:0] rise;
        logic [1:0] fall;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    sync_debounce #(
        .WIDTH    (2),
        .STAGES   (2),
        .DB_CYCLES(4)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .en      (en),
        .d       (d),
        .sync_raw(sync_raw),
        .q       (q),
        .rise    (rise),
        .fall    (fall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [1:0] act, input logic [1:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s actual=%b expected=%b", name, act, expv);
        end
    endtask

    // Drive one cycle of stimulus, queue its expectation, then compare after the edge.
    task automatic step(input string tag, input logic r, input logic e, input logic [1:0] dv,
                        input logic [1:0] esr, input logic [1:0] eq,
                        input logic [1:0] er, input logic [1:0] ef);
        exp_t x;
        reset = r;
        en    = e;
        d     = dv;
        sb.push_back('{tag, esr, eq, er, ef});
        @(posedge clk);
        #1;
        x = sb.pop_front();
        check({x.tag, ".sync_raw"}, sync_raw, x.sr);
        check({x.tag, ".q"}, q, x.q);
        check({x.tag, ".rise"}, rise, x.rise);
        check({x.tag, ".fall"}, fall, x.fall);
        $display("txn %s rst=%b en=%b d=%b -> sync_raw=%b q=%b rise=%b fall=%b",
                 x.tag, r, e, dv, sync_raw, q, rise, fall);
    endtask

    // Drops channel 0 from a settled high level back to idle.
    task automatic settle_low(input string tag);
        for (int k = 1; k <= 7; k++) begin
            step($sformatf("%s_low%0d", tag, k), 1'b1, 1'b1, 2'b00,
                 {1'b0, k < 2}, {1'b0, k < 6}, 2'b00, {1'b0, k == 6});
        end
    endtask

    initial begin
        reset = 1'b0;
        en    = 1'b1;
        d     = 2'b00;

        // rst_n, en, d, sync_raw, q, rise, fall
        vecs.push_back('{1'b0, 1'b1, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00});
        vecs.push_back('{1'b1, 1'b1, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00});
        for (int k = 0; k < 4; k++)
            vecs.push_back('{1'b1, 1'b1, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00});
        vecs.push_back('{1'b1, 1'b1, 2'b11, 2'b11, 2'b11, 2'b11, 2'b00});
        vecs.push_back('{1'b1, 1'b1, 2'b11, 2'b11, 2'b11, 2'b00, 2'b00});
        vecs.push_back('{1'b1, 1'b1, 2'b00, 2'b11, 2'b11, 2'b00, 2'b00});
        for (int k = 0; k < 4; k++)
            vecs.push_back('{1'b1, 1'b1, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00});
        vecs.push_back('{1'b1, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11});
        vecs.push_back('{1'b1, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00});
        vecs.push_back('{1'b1, 1'b1, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00});
        for (int k = 0; k < 4; k++)
            vecs.push_back('{1'b1, 1'b1, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00});
        vecs.push_back('{1'b1, 1'b1, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00});
        vecs.push_back('{1'b1, 1'b1, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00});
        vecs.push_back('{1'b1, 1'b1, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00});
        for (int k = 0; k < 4; k++)
            vecs.push_back('{1'b1, 1'b1, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00});
        vecs.push_back('{1'b1, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01});
        vecs.push_back('{1'b1, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00});

        @(posedge clk);
        #1;
        for (int i = 0; i < vecs.size(); i++) begin
            step($sformatf("vec%0d", i), vecs[i].rst_n, vecs[i].en, vecs[i].d,
                 vecs[i].sr, vecs[i].q, vecs[i].rise, vecs[i].fall);
        end

        // Three-sample glitch is rejected; a four-sample run is accepted and later released.
        for (int k = 1; k <= 8; k++) begin
            step($sformatf("glitch%0d", k), 1'b1, 1'b1, {1'b0, k <= 3},
                 {1'b0, k >= 2 && k <= 4}, 2'b00, 2'b00, 2'b00);
        end
        for (int k = 1; k <= 12; k++) begin
            step($sformatf("run4_%0d", k), 1'b1, 1'b1, {1'b0, k <= 4},
                 {1'b0, k >= 2 && k <= 5}, {1'b0, k >= 6 && k <= 9},
                 {1'b0, k == 6}, {1'b0, k == 10});
        end

        // Enable drops after two counted samples; count resumes where it left off.
        for (int k = 1; k <= 12; k++) begin
            step($sformatf("en%0d", k), 1'b1, (k < 5 || k > 9), 2'b01,
                 {1'b0, k >= 2}, {1'b0, k >= 11}, {1'b0, k == 11}, 2'b00);
        end
        settle_low("en");

        // Channel 1 chatters with two-sample runs while channel 0 rises normally.
        for (int k = 1; k <= 10; k++) begin
            logic [1:0] dv;
            logic       prev_d1;
            dv      = {((k - 1) >> 1) % 2 == 1, 1'b1};
            prev_d1 = (k >= 2) ? (((k - 2) >> 1) % 2 == 1) : 1'b0;
            step($sformatf("indep%0d", k), 1'b1, 1'b1, dv,
                 {prev_d1, k >= 2}, {1'b0, k >= 6}, {1'b0, k == 6}, 2'b00);
        end
        settle_low("indep");

        // Reset lands at count 3; the full latency applies again after release.
        for (int k = 1; k <= 13; k++) begin
            step($sformatf("rstmid%0d", k), (k != 6), 1'b1, 2'b01,
                 {1'b0, (k >= 2 && k <= 5) || k >= 8}, {1'b0, k >= 12},
                 {1'b0, k == 12}, 2'b00);
        end
        settle_low("rstmid");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
